// File: rtl/ysyx_22041071_pkg.sv
// Shared decode constants for the instruction-decode queue: opcodes, ALU codes,
// operand-select encodings and the bit positions of the out_ctrl bundle.
package ysyx_22041071_pkg;

  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;

  // blt/bltu reuse slt/sltu. Only twelve M codes fit below 'none', so remuw decodes illegal.
  typedef enum logic [4:0] {
    ALU_ADD, ALU_ADDW, ALU_SLL, ALU_SLLW, ALU_SRA, ALU_SRAW, ALU_SRL, ALU_SRLW,
    ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLTU, ALU_BEQ, ALU_BNE, ALU_BGE,
    ALU_BGEU, ALU_SUB, ALU_SUBW,
    ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU,
    ALU_MULW, ALU_DIVW, ALU_DIVUW, ALU_REMW,
    ALU_NONE = 5'h1f
  } alu_op_e;

  localparam logic [2:0] SRC1_REG  = 3'd0;
  localparam logic [2:0] SRC1_ZERO = 3'd4;
  localparam logic [2:0] SRC1_PC   = 3'd5;
  localparam logic [2:0] SRC2_REG  = 3'd0;
  localparam logic [2:0] SRC2_IMM  = 3'd1;
  localparam logic [2:0] SRC2_FOUR = 3'd5;

  localparam int CTRL_ILLEGAL  = 0;
  localparam int CTRL_REG_W_EN = 1;
  localparam int CTRL_WB_SEL   = 2;
  localparam int CTRL_MEM_W_EN = 3;
  localparam int CTRL_JALR     = 4;
  localparam int CTRL_BRCH     = 5;
  localparam int CTRL_SRC2_LSB = 6;
  localparam int CTRL_SRC1_LSB = 9;
  localparam int CTRL_W        = 12;

endpackage

// File: rtl/ysyx_22041071_id_fifo.sv
// Circular entry store for the decode queue; clear empties it in one cycle,
// the storage array itself is never initialised.
module ysyx_22041071_id_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rptr;
  logic [AW-1:0]    wptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rptr];

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !clear && do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/ysyx_22041071_idq.sv
// Instruction-decode queue: buffers fetched {pc, ins} and decodes the head entry.
// Define YSYX_22041071_M_EXT_EN to decode the RV64M multiply/divide group.
module ysyx_22041071_idq
  import ysyx_22041071_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_ins,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_ins,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic [11:0]     out_ctrl,
  output logic [4:0]      out_alu_ctrl,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc
);
  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // flush or a JAL leaving the head discards every entry, including any same-cycle push.
  logic [XLEN+31:0] head;
  logic             full, empty, push, pop, clear, jal_pop;
  logic [31:0]      ins;
  logic [6:0]       opcode;
  logic [2:0]       f3;
  logic [6:0]       f7;
  logic [XLEN-1:0]  imm_i, imm_s, imm_b, imm_u, imm_j;

  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign jal_pop   = out_valid & out_ready & ~flush & ~reset & (opcode == OPC_JAL);
  assign push      = in_valid & in_ready & ~flush & ~jal_pop;
  assign pop       = out_valid & out_ready & ~flush;
  assign clear     = flush | jal_pop;

  ysyx_22041071_id_fifo #(.WIDTH(XLEN + 32), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .clear (clear),
    .wdata ({in_pc, in_ins}),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign out_pc  = head[XLEN+31:32];
  assign ins     = head[31:0];
  assign out_ins = ins;
  assign opcode  = ins[6:0];
  assign f3      = ins[14:12];
  assign f7      = ins[31:25];
  assign out_rs1 = ins[19:15];
  assign out_rs2 = ins[24:20];
  assign out_rd  = ins[11:7];

  assign imm_i = {{(XLEN-12){ins[31]}}, ins[31:20]};
  assign imm_s = {{(XLEN-12){ins[31]}}, ins[31:25], ins[11:7]};
  assign imm_b = {{(XLEN-13){ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  assign imm_u = {{(XLEN-32){ins[31]}}, ins[31:12], 12'b0};
  assign imm_j = {{(XLEN-21){ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

  assign redirect    = jal_pop;
  assign redirect_pc = out_pc + imm_j;

  alu_op_e    alu;
  logic [2:0] src1, src2;
  logic       brch, jalr, mem_w, wb, reg_w, legal;

  always_comb begin
    out_imm = '0;
    alu = ALU_NONE;
    src1 = SRC1_REG;
    src2 = SRC2_REG;
    brch = 1'b0;
    jalr = 1'b0;
    mem_w = 1'b0;
    wb = 1'b0;
    reg_w = 1'b0;
    legal = 1'b1;
    case (opcode)
      OPC_LUI:   begin out_imm = imm_u; src1 = SRC1_ZERO; src2 = SRC2_IMM; alu = ALU_ADD; reg_w = 1'b1; end
      OPC_AUIPC: begin out_imm = imm_u; src1 = SRC1_PC; src2 = SRC2_IMM; alu = ALU_ADD; reg_w = 1'b1; end
      OPC_JAL:   begin out_imm = imm_j; src1 = SRC1_PC; src2 = SRC2_FOUR; alu = ALU_ADD; reg_w = 1'b1; end
      OPC_JALR: begin
        out_imm = imm_i; src1 = SRC1_PC; src2 = SRC2_FOUR; alu = ALU_ADD; jalr = 1'b1; reg_w = 1'b1;
        legal = (f3 == 3'b000);
      end
      OPC_BRANCH: begin
        out_imm = imm_b; brch = 1'b1;
        case (f3)
          3'b000:  alu = ALU_BEQ;
          3'b001:  alu = ALU_BNE;
          3'b100:  alu = ALU_SLT;
          3'b101:  alu = ALU_BGE;
          3'b110:  alu = ALU_SLTU;
          3'b111:  alu = ALU_BGEU;
          default: legal = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        out_imm = imm_i; src2 = SRC2_IMM; alu = ALU_ADD; wb = 1'b1; reg_w = 1'b1;
        legal = (f3 != 3'b111);
      end
      OPC_STORE: begin
        out_imm = imm_s; src2 = SRC2_IMM; alu = ALU_ADD; mem_w = 1'b1;
        legal = ~f3[2];
      end
      OPC_OP_IMM: begin
        out_imm = imm_i; src2 = SRC2_IMM; reg_w = 1'b1;
        case (f3)
          3'b000: alu = ALU_ADD;
          3'b001: begin alu = ALU_SLL; legal = (ins[31:26] == 6'b000000); end
          3'b010: alu = ALU_SLT;
          3'b011: alu = ALU_SLTU;
          3'b100: alu = ALU_XOR;
          3'b101: begin
            alu = ins[30] ? ALU_SRA : ALU_SRL;
            legal = (ins[31] == 1'b0) && (ins[29:26] == 4'b0000);
          end
          3'b110: alu = ALU_OR;
          default: alu = ALU_AND;
        endcase
      end
      OPC_OP_IMM_32: begin
        out_imm = imm_i; src2 = SRC2_IMM; reg_w = 1'b1;
        case (f3)
          3'b000:  alu = ALU_ADDW;
          3'b001:  begin alu = ALU_SLLW; legal = (f7 == 7'b0000000); end
          3'b101:  begin alu = f7[5] ? ALU_SRAW : ALU_SRLW; legal = ({f7[6], f7[4:0]} == 6'b0); end
          default: legal = 1'b0;
        endcase
      end
      OPC_OP: begin
        reg_w = 1'b1;
        case (f7)
          7'b0000000: begin
            case (f3)
              3'b000:  alu = ALU_ADD;
              3'b001:  alu = ALU_SLL;
              3'b010:  alu = ALU_SLT;
              3'b011:  alu = ALU_SLTU;
              3'b100:  alu = ALU_XOR;
              3'b101:  alu = ALU_SRL;
              3'b110:  alu = ALU_OR;
              default: alu = ALU_AND;
            endcase
          end
          7'b0100000: begin
            case (f3)
              3'b000:  alu = ALU_SUB;
              3'b101:  alu = ALU_SRA;
              default: legal = 1'b0;
            endcase
          end
`ifdef YSYX_22041071_M_EXT_EN
          7'b0000001: alu = alu_op_e'(5'(ALU_MUL) + {2'b00, f3});
`endif
          default: legal = 1'b0;
        endcase
      end
      OPC_OP_32: begin
        reg_w = 1'b1;
        case ({f7, f3})
          {7'b0000000, 3'b000}: alu = ALU_ADDW;
          {7'b0000000, 3'b001}: alu = ALU_SLLW;
          {7'b0000000, 3'b101}: alu = ALU_SRLW;
          {7'b0100000, 3'b000}: alu = ALU_SUBW;
          {7'b0100000, 3'b101}: alu = ALU_SRAW;
`ifdef YSYX_22041071_M_EXT_EN
          {7'b0000001, 3'b000}: alu = ALU_MULW;
          {7'b0000001, 3'b100}: alu = ALU_DIVW;
          {7'b0000001, 3'b101}: alu = ALU_DIVUW;
          {7'b0000001, 3'b110}: alu = ALU_REMW;
`endif
          default: legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase
    // An illegal word must not write state or reach a functional unit.
    if (!legal) begin
      alu = ALU_NONE;
      src1 = SRC1_REG;
      src2 = SRC2_REG;
      brch = 1'b0;
      jalr = 1'b0;
      mem_w = 1'b0;
      wb = 1'b0;
      reg_w = 1'b0;
    end
  end

  assign out_alu_ctrl = alu;
  assign out_ctrl     = {src1, src2, brch, jalr, mem_w, wb, reg_w, ~legal};

endmodule

// File: tb/tb_ysyx_22041071_idq.sv
// Bench for ysyx_22041071_idq: directed corner cases, then random traffic against
// a queue model with an independent table-driven decoder.
module tb_ysyx_22041071_idq;
  localparam int XLEN  = 64;
  localparam int DEPTH = 4;
  localparam int W     = XLEN + 32;
  localparam logic [31:0] ADDI = 32'h00100093;
`ifdef YSYX_22041071_M_EXT_EN
  localparam bit M_EN = 1'b1;
`else
  localparam bit M_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset, in_valid, in_ready, flush, out_valid, out_ready, redirect;
  logic [XLEN-1:0] in_pc, out_pc, out_imm, redirect_pc;
  logic [31:0]     in_ins, out_ins;
  logic [4:0]      out_rs1, out_rs2, out_rd, out_alu_ctrl;
  logic [11:0]     out_ctrl;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [63:0] imm;
    logic [11:0] ctrl;
    logic [4:0]  alu;
  } dec_t;

  ysyx_22041071_idq #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_ins(in_ins), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_ins(out_ins), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm), .out_ctrl(out_ctrl),
    .out_alu_ctrl(out_alu_ctrl), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic [63:0] pc, input logic [31:0] ins,
                        input logic rdy, input logic fl);
    in_valid = v; in_pc = pc; in_ins = ins; out_ready = rdy; flush = fl;
  endtask

  // Reference decoder: opcode picks format and operand shape, funct tables pick the op.
  function automatic dec_t ref_decode(input logic [31:0] ins);
    int rtab[8] = '{0, 2, 11, 12, 10, 6, 9, 8};
    int btab[8] = '{13, 14, -1, -1, 11, 15, 12, 16};
    logic [6:0] op = ins[6:0];
    logic [2:0] f3 = ins[14:12];
    logic [6:0] f7 = ins[31:25];
    logic [20:0] jimm = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    logic [12:0] bimm = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    logic [11:0] simm = {ins[31:25], ins[11:7]};
    logic [63:0] i_imm = longint'($signed(ins[31:20]));
    int code = -1;
    int s1 = 0, s2 = 0;
    bit br = 0, jr = 0, mw = 0, wbs = 0, rw = 0;
    dec_t d;
    d.imm = 64'd0;
    case (op)
      7'h37: begin d.imm = longint'($signed({ins[31:12], 12'h000})); s1 = 4; s2 = 1; code = 0; rw = 1; end
      7'h17: begin d.imm = longint'($signed({ins[31:12], 12'h000})); s1 = 5; s2 = 1; code = 0; rw = 1; end
      7'h6f: begin d.imm = longint'($signed(jimm)); s1 = 5; s2 = 5; code = 0; rw = 1; end
      7'h67: begin d.imm = i_imm; s1 = 5; s2 = 5; jr = 1; rw = 1; code = (f3 == 0) ? 0 : -1; end
      7'h63: begin d.imm = longint'($signed(bimm)); br = 1; code = btab[f3]; end
      7'h03: begin d.imm = i_imm; s2 = 1; wbs = 1; rw = 1; code = (f3 == 7) ? -1 : 0; end
      7'h23: begin d.imm = longint'($signed(simm)); s2 = 1; mw = 1; code = (f3 < 4) ? 0 : -1; end
      7'h13: begin
        d.imm = i_imm; s2 = 1; rw = 1;
        if (f3 == 1) code = (ins[31:26] == 0) ? 2 : -1;
        else if (f3 == 5) code = (ins[31:26] == 0) ? 6 : (ins[31:26] == 6'h10) ? 4 : -1;
        else code = rtab[f3];
      end
      7'h1b: begin
        d.imm = i_imm; s2 = 1; rw = 1;
        if (f3 == 0) code = 1;
        else if (f3 == 1 && f7 == 0) code = 3;
        else if (f3 == 5 && f7 == 0) code = 7;
        else if (f3 == 5 && f7 == 7'h20) code = 5;
      end
      7'h33: begin
        rw = 1;
        if (f7 == 0) code = rtab[f3];
        else if (f7 == 7'h20 && f3 == 0) code = 17;
        else if (f7 == 7'h20 && f3 == 5) code = 4;
        else if (f7 == 1 && M_EN) code = 19 + int'(f3);
      end
      7'h3b: begin
        rw = 1;
        if (f7 == 0 && f3 == 0) code = 1;
        else if (f7 == 0 && f3 == 1) code = 3;
        else if (f7 == 0 && f3 == 5) code = 7;
        else if (f7 == 7'h20 && f3 == 0) code = 18;
        else if (f7 == 7'h20 && f3 == 5) code = 5;
        else if (f7 == 1 && M_EN && f3 == 0) code = 27;
        else if (f7 == 1 && M_EN && f3 >= 4 && f3 <= 6) code = 24 + int'(f3);
      end
      default: code = -1;
    endcase
    if (code < 0) begin
      d.ctrl = 12'h001;
      d.alu = 5'h1f;
    end else begin
      d.ctrl = {3'(s1), 3'(s2), br, jr, mw, wbs, rw, 1'b0};
      d.alu = 5'(code);
    end
    return d;
  endfunction

  function automatic logic [31:0] rand_ins();
    logic [31:0] r = $urandom();
    case ($urandom_range(0, 11))
      0: r[6:0] = 7'h37;  1: r[6:0] = 7'h17;  2: r[6:0] = 7'h6f;  3: r[6:0] = 7'h67;
      4: r[6:0] = 7'h63;  5: r[6:0] = 7'h03;  6: r[6:0] = 7'h23;  7: r[6:0] = 7'h13;
      8: r[6:0] = 7'h1b;  9: r[6:0] = 7'h33;  10: r[6:0] = 7'h3b;
      default: ;
    endcase
    case ($urandom_range(0, 3))
      0: r[31:25] = 7'h00;
      1: r[31:25] = 7'h20;
      2: r[31:25] = 7'h01;
      default: ;
    endcase
    return r;
  endfunction

  task automatic check_head(input logic [W-1:0] e);
    dec_t d = ref_decode(e[31:0]);
    check("pc", out_pc, e[W-1:32]);
    check("ins", {32'd0, out_ins}, {32'd0, e[31:0]});
    check("rs1", {59'd0, out_rs1}, {59'd0, e[19:15]});
    check("rs2", {59'd0, out_rs2}, {59'd0, e[24:20]});
    check("rd", {59'd0, out_rd}, {59'd0, e[11:7]});
    check("imm", out_imm, d.imm);
    check("ctrl", {52'd0, out_ctrl}, {52'd0, d.ctrl});
    check("alu", {59'd0, out_alu_ctrl}, {59'd0, d.alu});
  endtask

  initial begin
    int n;
    logic exp_redirect, do_push, do_pop;
    logic [63:0] jal_off;

    reset = 1'b1;
    set_in(1'b1, 64'h0, ADDI, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    set_in(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
    #1;
    check("reset_out_valid", {63'd0, out_valid}, 64'd0);
    check("reset_in_ready", {63'd0, in_ready}, 64'd1);
    check("reset_redirect", {63'd0, redirect}, 64'd0);

    // fill to DEPTH with the consumer stalled
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      set_in(1'b1, 64'h1000 + 64'(4 * i), ADDI, 1'b0, 1'b0);
    end
    @(negedge clk);
    set_in(1'b1, 64'h1010, ADDI, 1'b0, 1'b0);
    #1;
    check("full_in_ready", {63'd0, in_ready}, 64'd0);
    check("full_out_valid", {63'd0, out_valid}, 64'd1);
    check("addi_alu", {59'd0, out_alu_ctrl}, 64'd0);
    check("addi_ctrl", {52'd0, out_ctrl}, 64'h042);
    check("addi_imm", out_imm, 64'd1);
    @(negedge clk);
    // full queue: pop accepted, offered push refused
    set_in(1'b1, 64'h1014, ADDI, 1'b1, 1'b0);
    #1;
    check("full_pop_in_ready", {63'd0, in_ready}, 64'd0);
    check("full_pop_head", out_pc, 64'h1000);
    @(negedge clk);
    set_in(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
    #1;
    check("after_pop_in_ready", {63'd0, in_ready}, 64'd1);
    n = 0;
    for (int k = 0; k < 8; k++) begin
      if (!out_valid) break;
      check("drain_pc", out_pc, 64'h1004 + 64'(4 * n));
      n++;
      @(negedge clk);
      #1;
    end
    check("count_after_full_pop", 64'(n), 64'd3);

    // JAL at head with two wrong-path entries behind it
    @(negedge clk);
    set_in(1'b1, 64'h80000000, 32'h008000EF, 1'b0, 1'b0);
    @(negedge clk);
    set_in(1'b1, 64'h80000004, ADDI, 1'b0, 1'b0);
    @(negedge clk);
    set_in(1'b1, 64'h80000008, ADDI, 1'b0, 1'b0);
    @(negedge clk);
    set_in(1'b1, 64'h9000, ADDI, 1'b1, 1'b0);
    #1;
    check("jal_redirect", {63'd0, redirect}, 64'd1);
    check("jal_redirect_pc", redirect_pc, 64'h80000008);
    @(negedge clk);
    set_in(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
    #1;
    check("jal_then_empty", {63'd0, out_valid}, 64'd0);

    // flush with three entries and a concurrent push
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      set_in(1'b1, 64'h2000 + 64'(4 * i), ADDI, 1'b0, 1'b0);
    end
    @(negedge clk);
    set_in(1'b1, 64'hdead0, 32'h0000006f, 1'b1, 1'b1);
    #1;
    check("flush_no_redirect", {63'd0, redirect}, 64'd0);
    @(negedge clk);
    set_in(1'b1, 64'h3000, ADDI, 1'b0, 1'b0);
    #1;
    check("flush_out_valid", {63'd0, out_valid}, 64'd0);
    check("flush_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    set_in(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
    #1;
    check("after_flush_head", out_pc, 64'h3000);
    @(negedge clk);
    #1;
    check("after_flush_single", {63'd0, out_valid}, 64'd0);

    // mul at head
    set_in(1'b1, 64'h4000, 32'h02B50533, 1'b0, 1'b0);
    @(negedge clk);
    set_in(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
    #1;
    check("mul_alu", {59'd0, out_alu_ctrl}, M_EN ? 64'd19 : 64'h1f);
    check("mul_illegal", {63'd0, out_ctrl[0]}, M_EN ? 64'd0 : 64'd1);
    @(negedge clk);

    // random traffic against the queue model
    exp_q.delete();
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 999) == 0);
      set_in($urandom_range(0, 3) != 0, {$urandom(), $urandom()}, rand_ins(),
             $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
      #1;
      exp_redirect = (exp_q.size() != 0) && out_ready && !flush && (exp_q[0][6:0] == 7'h6f);
      if (!reset) begin
        check("in_ready", {63'd0, in_ready}, {63'd0, exp_q.size() < DEPTH});
        check("out_valid", {63'd0, out_valid}, {63'd0, exp_q.size() != 0});
        check("redirect", {63'd0, redirect}, {63'd0, exp_redirect});
        if (exp_q.size() != 0) check_head(exp_q[0]);
        if (exp_redirect) begin
          jal_off = ref_decode(exp_q[0][31:0]).imm;
          check("redirect_pc", redirect_pc, exp_q[0][W-1:32] + jal_off);
        end
      end
      if (reset || flush || exp_redirect) begin
        exp_q.delete();
      end else begin
        do_push = in_valid && (exp_q.size() < DEPTH);
        do_pop = (exp_q.size() != 0) && out_ready;
        if (do_pop) void'(exp_q.pop_front());
        if (do_push) exp_q.push_back({in_pc, in_ins});
      end
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
